// File: rtl/step_pkg.sv
// -----------------------------------------------------------------------------
// step_pkg
// Shared types and constants for the step-counter command path.
//   cmd_op_e    : command opcodes (LOAD / STEP3 / STEP1 / HOLD)
//   C_*         : counter control encodings driven on c
//   cmd_t       : one queued command {op, arg}
//   ctrl_t      : registered counter-control bundle {load, count_en, c, data_in}
//   encode_cmd  : maps a command onto its counter-control values
//   first_rem   : initial repeat count for a command (LOAD always lasts 1 cycle)
// -----------------------------------------------------------------------------
package step_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STEP3 = 2'd1,
        OP_STEP1 = 2'd2,
        OP_HOLD  = 2'd3
    } cmd_op_e;

    localparam logic [1:0] C_PLUS3 = 2'b00;
    localparam logic [1:0] C_PLUS1 = 2'b01;
    localparam logic [1:0] C_HOLD  = 2'b11;

    typedef struct packed {
        cmd_op_e    op;
        logic [3:0] arg;
    } cmd_t;

    typedef struct packed {
        logic       load;
        logic       count_en;
        logic [1:0] c;
        logic [3:0] data_in;
    } ctrl_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam ctrl_t CTRL_IDLE = '{load: 1'b0, count_en: 1'b0, c: C_HOLD, data_in: 4'd0};

    function automatic ctrl_t encode_cmd(input cmd_t cmd);
        ctrl_t ctrl;
        ctrl = '{load: 1'b0, count_en: 1'b1, c: C_HOLD, data_in: 4'd0};
        case (cmd.op)
            OP_LOAD: begin
                ctrl.load     = 1'b1;
                ctrl.count_en = 1'b0;
                ctrl.data_in  = cmd.arg;
            end
            OP_STEP3: ctrl.c = C_PLUS3;
            OP_STEP1: ctrl.c = C_PLUS1;
            default:  ctrl.c = C_HOLD;
        endcase
        return ctrl;
    endfunction

    // For repeating commands arg is "count minus one", so it is the number of
    // cycles still to run after the first one.
    function automatic logic [3:0] first_rem(input cmd_t cmd);
        return (cmd.op == OP_LOAD) ? 4'd0 : cmd.arg;
    endfunction

endpackage

// File: rtl/step_cmd_fifo.sv
// -----------------------------------------------------------------------------
// step_cmd_fifo
// Synchronous command FIFO, DEPTH entries (power of 2, >= 2).
//   clk, reset        : clock, async active-low reset
//   flush             : synchronous clear of pointers and level (beats push/pop)
//   i_push/i_push_data: write request; ignored while full
//   i_pop             : read request; ignored while empty
//   o_pop_data        : entry at the read pointer (valid when !o_empty)
//   o_full, o_empty   : occupancy flags
//   o_level           : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module step_cmd_fifo
    import step_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        i_push,
    input  cmd_t        i_push_data,
    input  logic        i_pop,
    output cmd_t        o_pop_data,
    output logic        o_full,
    output logic        o_empty,
    output logic [AW:0] o_level
);

    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full     = (r_level == (AW+1)'(DEPTH));
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign o_pop_data = r_mem[r_rd_ptr];

    assign w_push_ok = i_push && !o_full  && !flush;
    assign w_pop_ok  = i_pop  && !o_empty && !flush;

    // NOTE: the storage array has no reset; pointers and level alone say
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/step_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// step_cmd_sequencer
// Queues step commands and replays each onto the 4-bit step counter's control
// inputs for its programmed number of cycles, back to back with no bubbles.
//   clk, reset          : clock, async active-low reset
//   flush               : synchronous clear of FIFO and FSM (drops a same-cycle push)
//   cmd_valid/cmd_ready : command handshake; cmd_ready = !full
//   cmd_op, cmd_arg     : opcode and argument (LOAD value or repeat count - 1)
//   load, count_en, c,
//   data_in             : registered counter controls
//   busy                : running a command or commands queued
//   level               : FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module step_cmd_sequencer
    import step_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_arg,
    output logic        load,
    output logic        count_en,
    output logic [1:0]  c,
    output logic [3:0]  data_in,
    output logic        busy,
    output logic [AW:0] level
);

    state_e     r_state;
    state_e     w_state_nxt;
    logic [3:0] r_rem;
    logic [3:0] w_rem_nxt;
    ctrl_t      r_ctrl;
    ctrl_t      w_ctrl_nxt;

    cmd_t        w_push_cmd;
    cmd_t        w_head;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [AW:0] w_level;

    assign w_push_cmd = '{op: cmd_op_e'(cmd_op), arg: cmd_arg};

    step_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .i_push      (cmd_valid),
        .i_push_data (w_push_cmd),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (w_level)
    );

    // State and output registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_ctrl  <= CTRL_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_ctrl  <= w_ctrl_nxt;
        end
    end

    // Next-state logic. A pop happens whenever the current command is on its
    // last cycle (or there is none), so queued commands follow with no gap.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_ctrl_nxt  = r_ctrl;
        w_pop       = 1'b0;

        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_rem_nxt   = '0;
            w_ctrl_nxt  = CTRL_IDLE;
        end else if (!w_empty && (r_state == ST_IDLE || r_rem == '0)) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_RUN;
            w_rem_nxt   = first_rem(w_head);
            w_ctrl_nxt  = encode_cmd(w_head);
        end else if (r_state == ST_RUN) begin
            if (r_rem != '0) begin
                w_rem_nxt = r_rem - 1'b1;
            end else begin
                w_state_nxt = ST_IDLE;
                w_ctrl_nxt  = CTRL_IDLE;
            end
        end
    end

    // Output logic.
    always_comb begin
        load      = r_ctrl.load;
        count_en  = r_ctrl.count_en;
        c         = r_ctrl.c;
        data_in   = r_ctrl.data_in;
        level     = w_level;
        cmd_ready = !w_full;
        busy      = (r_state == ST_RUN) || (w_level != '0);
    end

endmodule
